ext_pipe: RTL
=============

EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 Parameter W, default 32: datapath and output width; SHALL equal IDX_W+6.
REQ-002 Parameter IMM_W, default 16: immediate width; SHALL be less than W.
REQ-003 Parameter IDX_W, default 26: jump index width.
REQ-004 Parameter STAGES, default 1, legal 1..3: number of register stages between input and output.
REQ-005 clk  in  1  the only clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-007 in_valid  in  1  input operands are valid this cycle.
REQ-008 stall  in  1  freezes every stage and holds the outputs.
REQ-009 flush  in  1  invalidates every stage.
REQ-010 op  in  3  operation select (REQ-015).
REQ-011 imm  in  IMM_W  instruction immediate.
REQ-012 instr_index  in  IDX_W  jump target index.
REQ-013 pc  in  W  PC of the instruction.
REQ-014 mem_data  in  W  loaded word; addr_lo  in  2  low bits of the load address; out_valid  out  1; out_data  out  W; misalign  out  1  halfword load misaligned; err_cnt  out  8  misaligned-load count.

Function
REQ-015 The op encodings SHALL be as follows:
- 000: zero-extend imm.
- 001: {imm, (W-IMM_W) zeros}.
- 010: {pc[W-1:W-4], instr_index, 2'b00}.
- 011: sign-extend imm.
- 100: pc + 4 + (sign-extend(imm) << 2), computed modulo 2^W.
- 101: lb, byte addr_lo of mem_data, sign-extended.
- 110: lbu, same byte, zero-extended.
- 111: lh, halfword addr_lo[1] of mem_data, sign-extended.
REQ-016 Byte 0 SHALL be mem_data[7:0] and halfword 0 SHALL be mem_data[15:0] (little-endian lanes).
REQ-017 For op 111 with addr_lo[0]=1, the result SHALL be 0 and the stage's misalign bit SHALL be 1; misalign SHALL be 0 for every other case.
REQ-018 The result SHALL be computed combinationally and captured into stage 1 together with in_valid and the misalign bit.
REQ-019 Stage k SHALL capture stage k-1 each cycle; out_valid, out_data and misalign SHALL be driven by stage STAGES.
REQ-020 Latency SHALL be exactly STAGES cycles from an accepted input to out_valid, with no bubbles under continuous in_valid.
REQ-021 stall=1 SHALL hold all stage registers and err_cnt unchanged, and the input SHALL be ignored that cycle.
REQ-022 flush=1 SHALL clear all valid and misalign bits on that edge, and the input SHALL be ignored; flush SHALL have priority over stall.
REQ-023 Data bits of invalid stages are don't-care, but out_data SHALL be 0 whenever out_valid=0.
REQ-024 err_cnt SHALL increment by 1 on each edge where stage STAGES holds valid=1 and misalign=1, stall=0 and flush=0.
REQ-025 err_cnt SHALL saturate at 255 and never wrap.
REQ-026 A misaligned result flushed before reaching the last stage SHALL NOT be counted.
REQ-027 Simultaneous in_valid and flush: flush SHALL win, and out_valid SHALL be 0 STAGES cycles later.

Reset
REQ-028 While reset=1, all valid bits, misalign, out_valid, out_data and err_cnt SHALL be 0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight results.
REQ-030 The first input accepted after reset deasserts SHALL emerge after STAGES cycles.

Verification
REQ-031 STAGES=1, op=011, imm=16'h8000, in_valid=1 -> next cycle out_valid=1, out_data=32'hFFFF8000.
REQ-032 STAGES=1, op=100, pc=32'h00003000, imm=16'hFFFF -> out_data=32'h00003000.
REQ-033 STAGES=1, op=010, pc=32'hA0000000, instr_index=26'h0000C00 -> out_data=32'hA0003000.
REQ-034 Loads with mem_data=32'h80FF7F01:
- op=101, addr_lo=3 -> 32'hFFFFFF80.
- op=110, addr_lo=2 -> 32'h000000FF.
- op=111, addr_lo=2 -> 32'hFFFF80FF.
- op=111, addr_lo=1 -> out_data=0, misalign=1, err_cnt increments to 1.
REQ-035 STAGES=3, three back-to-back inputs, then stall=1 for 2 cycles, then flush=1 on the cycle the second result is at the output:
- The stall holds out_data steady for 2 cycles.
- After the flush, out_valid=0 and the third result never appears.
REQ-036 300 consecutive misaligned lh inputs -> err_cnt=255 and held; assert reset asynchronously mid-stream -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/ext_pipe_if.sv
// ext_pipe_if: operand and result bundle for the ext_pipe extension/load-align pipe.
//   master : drives in_valid, stall, flush, op, imm, instr_index, pc, mem_data, addr_lo;
//            observes out_valid, out_data, misalign, err_cnt.
//   slave  : the pipe itself (mirror image of master).
// W must equal IDX_W+6 so that the jump-target form {pc[top4], index, 00} fills W.
interface ext_pipe_if #(
  parameter int W     = 32,
  parameter int IMM_W = 16,
  parameter int IDX_W = 26
);
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [2:0]       op;
  logic [IMM_W-1:0] imm;
  logic [IDX_W-1:0] instr_index;
  logic [W-1:0]     pc;
  logic [W-1:0]     mem_data;
  logic [1:0]       addr_lo;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             misalign;
  logic [7:0]       err_cnt;

  modport master (
    output in_valid, stall, flush, op, imm, instr_index, pc, mem_data, addr_lo,
    input  out_valid, out_data, misalign, err_cnt
  );

  modport slave (
    input  in_valid, stall, flush, op, imm, instr_index, pc, mem_data, addr_lo,
    output out_valid, out_data, misalign, err_cnt
  );
endinterface

// File: rtl/ext_pipe.sv
// ext_pipe: immediate-extension / jump-target / load-alignment unit followed by a
// STAGES-deep register pipe with stall, flush and a saturating misaligned-load counter.
//   clk   : sole clock, rising edge.
//   reset : asynchronous, active-high; clears every stage and err_cnt.
//   bus   : ext_pipe_if slave (operands in, result/valid/misalign/err_cnt out).
// Parameters: W (= IDX_W+6), IMM_W (< W), IDX_W, STAGES (1..3).
// The byte/halfword lane selects assume W >= 32 (a full loaded word).
module ext_pipe #(
  parameter int W      = 32,
  parameter int IMM_W  = 16,
  parameter int IDX_W  = 26,
  parameter int STAGES = 1
) (
  input logic       clk,
  input logic       reset,
  ext_pipe_if.slave bus
);

  logic [W-1:0] imm_zext;
  logic [W-1:0] imm_sext;
  logic [7:0]   byte_sel;
  logic [15:0]  half_sel;
  logic [W-1:0] res;
  logic         mis_c;

  // Result of the current operands; captured into stage 0 unless stalled/flushed.
  always_comb begin
    imm_zext = {{(W-IMM_W){1'b0}}, bus.imm};
    imm_sext = {{(W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};

    // Little-endian lanes: byte 0 is mem_data[7:0], halfword 0 is mem_data[15:0].
    case (bus.addr_lo)
      2'd0:    byte_sel = bus.mem_data[7:0];
      2'd1:    byte_sel = bus.mem_data[15:8];
      2'd2:    byte_sel = bus.mem_data[23:16];
      default: byte_sel = bus.mem_data[31:24];
    endcase
    half_sel = bus.addr_lo[1] ? bus.mem_data[31:16] : bus.mem_data[15:0];

    res   = '0;
    mis_c = 1'b0;
    case (bus.op)
      3'b000: res = imm_zext;
      3'b001: res = {bus.imm, {(W-IMM_W){1'b0}}};
      3'b010: res = {bus.pc[W-1:W-4], bus.instr_index, 2'b00};
      3'b011: res = imm_sext;
      // Branch target; the adder wraps naturally at W bits.
      3'b100: res = bus.pc + {{(W-3){1'b0}}, 3'b100} + {imm_sext[W-3:0], 2'b00};
      3'b101: res = {{(W-8){byte_sel[7]}}, byte_sel};
      3'b110: res = {{(W-8){1'b0}}, byte_sel};
      default: begin
        if (bus.addr_lo[0]) begin
          res   = '0;
          mis_c = 1'b1;
        end else begin
          res = {{(W-16){half_sel[15]}}, half_sel};
        end
      end
    endcase
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] mis;
  logic [W-1:0]      dat [STAGES];
  logic [7:0]        err_q;

  // Flush beats stall; a stalled cycle neither advances the pipe nor counts errors.
  // The misalign bit is qualified by in_valid so it can only ever be set on a valid stage.
  // err_cnt counts a misaligned result as it leaves the last stage, so a result held
  // there by stall is counted exactly once, and one flushed earlier never is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld   <= '0;
      mis   <= '0;
      err_q <= '0;
      for (int k = 0; k < STAGES; k++) dat[k] <= '0;
    end else if (bus.flush) begin
      vld <= '0;
      mis <= '0;
    end else if (!bus.stall) begin
      vld[0] <= bus.in_valid;
      mis[0] <= bus.in_valid & mis_c;
      dat[0] <= res;
      for (int k = 1; k < STAGES; k++) begin
        vld[k] <= vld[k-1];
        mis[k] <= mis[k-1];
        dat[k] <= dat[k-1];
      end
      if (vld[STAGES-1] && mis[STAGES-1] && (err_q != 8'hFF))
        err_q <= err_q + 8'd1;
    end
  end

  assign bus.out_valid = vld[STAGES-1];
  assign bus.out_data  = vld[STAGES-1] ? dat[STAGES-1] : '0;
  assign bus.misalign  = mis[STAGES-1];
  assign bus.err_cnt   = err_q;

endmodule
